// File: rtl/la_pkg.sv
// Shared state encoding, frame marker bytes and sizing helpers for the
// logic-analyser capture/readout sequencer.
package la_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_GUARD,
        ST_WAIT_DONE,
        ST_HDR,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_TRL,
        ST_ERR
    } la_state_e;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] TRL_BYTE = 8'h5A;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    function automatic int bytes_per_word(input int word_width);
        return word_width / 8;
    endfunction

    // Width of a counter that must hold values 0..max_count inclusive.
    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Parallel-load, MSB-first byte serializer with a valid/ready output and a
// last-byte flag; marker bytes are sent by loading a single left-aligned byte.
module byte_serializer
    import la_pkg::*;
#(
    parameter  int WORD_WIDTH = 32,
    localparam int BPW        = bytes_per_word(WORD_WIDTH),
    localparam int CW         = count_width(BPW)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_data,
    input  logic [CW-1:0]         load_bytes,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  last,
    output logic                  xfer
);

    logic [WORD_WIDTH-1:0] shift_reg;
    logic [WORD_WIDTH-1:0] shift_next;
    logic [CW-1:0]         count_reg;
    logic                  valid_reg;

    // Each byte lane takes the lane below it; lane 0 refills with zeros.
    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            if (gi == 0) begin : g_bottom
                assign shift_next[7:0] = 8'h00;
            end else begin : g_upper
                assign shift_next[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    assign xfer      = valid_reg & out_ready;
    assign last      = (count_reg == CW'(1));
    assign out_data  = shift_reg[WORD_WIDTH-1 -: 8];
    assign out_valid = valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            shift_reg <= load_data;
            count_reg <= load_bytes;
            valid_reg <= (load_bytes != '0);
        end else if (xfer) begin
            shift_reg <= shift_next;
            count_reg <= count_reg - CW'(1);
            valid_reg <= !last;
        end
    end

endmodule

// File: rtl/la_capture_sequencer.sv
// Capture/readout controller: strobes the analyser, waits for done with a
// timeout, then streams every capture word as a framed byte stream.
module la_capture_sequencer
    import la_pkg::*;
#(
    parameter int CAPTURE_DEPTH = 11,
    parameter int WORD_WIDTH    = 32,
    parameter int TIMEOUT_WIDTH = 24,
    parameter int DONE_GUARD    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     capture,
    input  logic                     done,
    output logic [CAPTURE_DEPTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0]    mem_data,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     timed_out
);

    localparam int BPW = bytes_per_word(WORD_WIDTH);
    localparam int BCW = count_width(BPW);
    localparam int GW  = (DONE_GUARD > 1) ? $clog2(DONE_GUARD) : 1;

    la_state_e                state_reg, state_next;
    logic [GW-1:0]            guard_reg, guard_next;
    logic [TIMEOUT_WIDTH-1:0] tmo_reg, tmo_next, tmo_inc;
    logic [CAPTURE_DEPTH-1:0] addr_reg, addr_next;
    logic                     timed_out_reg, timed_out_next;

    logic                     ser_clear;
    logic                     ser_load;
    logic                     ser_last;
    logic                     ser_xfer;
    logic [WORD_WIDTH-1:0]    ser_word;
    logic [BCW-1:0]           ser_bytes;

    function automatic logic [WORD_WIDTH-1:0] frame_word(input logic [7:0] b);
        return WORD_WIDTH'(b) << (WORD_WIDTH - 8);
    endfunction

    byte_serializer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ser_clear),
        .load      (ser_load),
        .load_data (ser_word),
        .load_bytes(ser_bytes),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (ser_last),
        .xfer      (ser_xfer)
    );

    assign tmo_inc   = tmo_reg + TIMEOUT_WIDTH'(1);
    assign busy      = (state_reg != ST_IDLE);
    assign capture   = (state_reg == ST_ARM);
    assign mem_addr  = addr_reg;
    assign timed_out = timed_out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            guard_reg     <= '0;
            tmo_reg       <= '0;
            addr_reg      <= '0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            guard_reg     <= guard_next;
            tmo_reg       <= tmo_next;
            addr_reg      <= addr_next;
            timed_out_reg <= timed_out_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        guard_next     = guard_reg;
        tmo_next       = tmo_reg;
        addr_next      = addr_reg;
        timed_out_next = timed_out_reg;
        ser_clear      = 1'b0;
        ser_load       = 1'b0;
        ser_word       = '0;
        ser_bytes      = BCW'(1);

        // Abort beats every transition and drops any byte in flight.
        if (abort) begin
            state_next = ST_IDLE;
            ser_clear  = 1'b1;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        timed_out_next = 1'b0;
                        state_next     = ST_ARM;
                    end
                end
                ST_ARM: begin
                    guard_next = '0;
                    state_next = ST_GUARD;
                end
                ST_GUARD: begin
                    if (guard_reg == GW'(DONE_GUARD - 1)) begin
                        tmo_next   = '0;
                        state_next = ST_WAIT_DONE;
                    end else begin
                        guard_next = guard_reg + GW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (done) begin
                        ser_load   = 1'b1;
                        ser_word   = frame_word(HDR_BYTE);
                        state_next = ST_HDR;
                    end else begin
                        tmo_next = tmo_inc;
                        if (&tmo_inc) begin
                            timed_out_next = 1'b1;
                            ser_load       = 1'b1;
                            ser_word       = frame_word(ERR_BYTE);
                            state_next     = ST_ERR;
                        end
                    end
                end
                ST_HDR: begin
                    if (ser_xfer) begin
                        addr_next  = '0;
                        state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    ser_load   = 1'b1;
                    ser_word   = mem_data;
                    ser_bytes  = BCW'(BPW);
                    state_next = ST_SEND;
                end
                ST_SEND: begin
                    if (ser_xfer && ser_last) begin
                        if (&addr_reg) begin
                            ser_load   = 1'b1;
                            ser_word   = frame_word(TRL_BYTE);
                            state_next = ST_TRL;
                        end else begin
                            addr_next  = addr_reg + CAPTURE_DEPTH'(1);
                            state_next = ST_FETCH;
                        end
                    end
                end
                ST_TRL: begin
                    // The address wraps back to zero only as the trailer leaves.
                    if (ser_xfer) begin
                        addr_next  = '0;
                        state_next = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (ser_xfer) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_capture_sequencer.sv
// Directed-plus-random bench for la_capture_sequencer against a frame-level
// reference built from the capture memory contents.
module tb_la_capture_sequencer;

    localparam int CD     = 2;
    localparam int WW     = 32;
    localparam int TW     = 4;
    localparam int DG     = 4;
    localparam int NWORDS = 1 << CD;
    localparam int BPW    = WW / 8;
    localparam logic [31:0] FIXED_WORDS [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          done = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          capture;
    logic          out_valid;
    logic          timed_out;
    logic [CD-1:0] mem_addr;
    logic [WW-1:0] mem_data;
    logic [7:0]    out_data;
    logic [WW-1:0] mem [NWORDS];

    int            checks = 0;
    int            failures = 0;
    int            cycle = 0;
    logic [7:0]    rx [$];
    int            cap_at = -1;
    int            cap_cycles = 0;
    int            first_valid = -1;
    int            last_valid = -1;
    bit            prev_stall = 1'b0;
    logic [7:0]    prev_data = 8'h00;

    always #5 clk = ~clk;

    la_capture_sequencer #(
        .CAPTURE_DEPTH(CD),
        .WORD_WIDTH   (WW),
        .TIMEOUT_WIDTH(TW),
        .DONE_GUARD   (DG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .capture  (capture),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .timed_out(timed_out)
    );

    // Analyser read port: synchronous RAM, data one cycle after the address.
    always @(posedge clk) begin
        cycle    <= cycle + 1;
        mem_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: collects accepted bytes and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (capture) begin
                cap_cycles++;
                cap_at = cycle;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cycle;
                last_valid = cycle;
            end
            if (out_valid && out_ready && !abort) begin
                if (rx.size() >= 1 && rx.size() <= NWORDS * BPW)
                    chk("addr_during_word", mem_addr, (rx.size() - 1) / BPW);
                rx.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input bit fixed);
        for (int i = 0; i < NWORDS; i++) mem[i] = fixed ? FIXED_WORDS[i] : $urandom;
    endtask

    task automatic check_bytes(input string tag, input bit err_frame);
        logic [7:0] exp_q [$];
        exp_q = {};
        if (err_frame) begin
            exp_q.push_back(8'hEE);
        end else begin
            exp_q.push_back(8'hA5);
            for (int w = 0; w < NWORDS; w++)
                for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(mem[w][b*8 +: 8]);
            exp_q.push_back(8'h5A);
        end
        chk($sformatf("%s_len", tag), rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rx[i], exp_q[i]);
    endtask

    // ready_mode: 0 always ready, 1 toggle with a 7-cycle stall, 2 random, 3 never.
    task automatic run_frame(input int ready_mode, input int done_delay, input bit start_mid,
                             input int abort_at, input int reset_at);
        int toggle;
        int stall_left;
        bit stalled;
        bit poked;
        bit aborted;
        bit ended;
        int start_cyc;
        toggle = 1; stall_left = 0; stalled = 0; poked = 0; aborted = 0; ended = 0;
        rx.delete();
        cap_at = -1; cap_cycles = 0; first_valid = -1; last_valid = -1;
        start = 1'b1;
        start_cyc = cycle;
        tick();
        start = 1'b0;
        chk("start_clears_timeout", timed_out, 0);
        for (int n = 0; n < 3000 && !ended; n++) begin
            if (done_delay >= 0 && cap_at >= 0 && cycle >= cap_at + done_delay) done = 1'b1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    if (!stalled && rx.size() == 7) begin
                        stalled = 1; stall_left = 7;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0; stall_left--;
                    end else begin
                        out_ready = toggle[0]; toggle ^= 1;
                    end
                end
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            start = (start_mid && !poked && rx.size() == 6);
            if (start) poked = 1;
            abort = 1'b0;
            if (abort_at >= 0 && !aborted && out_valid && rx.size() == abort_at) begin
                abort = 1'b1; aborted = 1;
            end
            if (reset_at >= 0 && out_valid && rx.size() == reset_at) begin
                #2 rst_n = 1'b0;
                #1 chk("reset_async_zero", {busy, capture, mem_addr, out_valid, out_data, timed_out}, 0);
                ended = 1;
                break;
            end
            tick();
            ended = !busy;
        end
        start = 1'b0; abort = 1'b0; done = 1'b0; out_ready = 1'b0;
        chk("frame_end", ended, 1);
        chk("start_to_capture", cap_at - start_cyc, 1);
        chk("capture_width", cap_cycles, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle=%0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        fill_mem(1);
        repeat (2) tick();
        chk("reset_state", {busy, capture, mem_addr, out_valid, out_data, timed_out}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", busy, 0);

        // Normal frame with the fixed word set, always ready.
        fill_mem(1);
        run_frame(0, 10, 0, -1, -1);
        check_bytes("normal", 0);
        chk("trailer_offset", last_valid - first_valid, 1 + NWORDS * (2 + BPW));
        chk("addr_wrapped", mem_addr, 0);
        chk("normal_timed_out", timed_out, 0);
        $display("frame normal: %0d bytes", rx.size());

        // Backpressure: toggling ready with a long mid-word stall.
        run_frame(1, 10, 0, -1, -1);
        check_bytes("backpressure", 0);
        $display("frame backpressure: %0d bytes", rx.size());

        // Timeout: done never rises.
        run_frame(0, -1, 0, -1, -1);
        check_bytes("timeout", 1);
        chk("timeout_latency", first_valid - cap_at, DG + 1 + (2 ** TW - 1));
        chk("timeout_sticky", timed_out, 1);
        $display("frame timeout: %0d bytes timed_out=%0b", rx.size(), timed_out);

        // Stale done held high through the guard window.
        fill_mem(0);
        done = 1'b1;
        run_frame(0, 0, 0, -1, -1);
        check_bytes("stale_done", 0);
        chk("stale_done_hdr_cycle", first_valid - cap_at, DG + 2);
        $display("frame stale_done: hdr %0d cycles after capture", first_valid - cap_at);

        // Abort while the second byte of word 1 is presented.
        fill_mem(0);
        run_frame(0, 10, 0, 6, -1);
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_busy", busy, 0);
        out_ready = 1'b1;
        repeat (20) tick();
        out_ready = 1'b0;
        chk("abort_no_more_bytes", rx.size(), 6);
        $display("frame abort: %0d bytes before abort", rx.size());

        // Full frame after abort, random backpressure.
        fill_mem(0);
        run_frame(2, 7, 0, -1, -1);
        check_bytes("after_abort", 0);
        $display("frame after_abort: %0d bytes", rx.size());

        // Abort while the error byte is stalled: timed_out must survive.
        run_frame(3, -1, 0, 0, -1);
        chk("abort_err_timed_out", timed_out, 1);
        chk("abort_err_no_bytes", rx.size(), 0);
        chk("abort_err_busy", busy, 0);
        $display("frame abort_err: timed_out=%0b", timed_out);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle_busy", busy, 0);
        chk("start_abort_idle_capture", capture, 0);
        tick();
        chk("start_abort_idle_timed_out", timed_out, 1);
        $display("idle start+abort: busy=%0b", busy);

        // start pulsed during SEND is ignored.
        fill_mem(0);
        run_frame(0, 3, 1, -1, -1);
        check_bytes("start_while_busy", 0);
        chk("start_while_busy_len", last_valid - first_valid, 1 + NWORDS * (2 + BPW));
        $display("frame start_while_busy: %0d bytes", rx.size());

        // Asynchronous reset in the middle of word 2.
        fill_mem(0);
        run_frame(0, 5, 0, -1, 10);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", busy, 0);
        $display("frame reset_mid_send: %0d bytes before reset", rx.size());

        // Random frames.
        for (int k = 0; k < 3; k++) begin
            fill_mem(0);
            run_frame(2, $urandom_range(0, 20), 0, -1, -1);
            check_bytes($sformatf("random%0d", k), 0);
            $display("frame random%0d: %0d bytes", k, rx.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
